// File: rtl/capture_trigger.sv
// Trigger-and-capture stage behind the LVDS input capture: arms on command, waits for a
// masked level or edge trigger, then streams a fixed-length burst into the capture FIFO.
module capture_trigger #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              strob_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic              trig_edge_i,
  input  logic [CNT_W-1:0]  capture_len_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_o,
  output logic [DATA_W-1:0] fifo_data_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [CNT_W-1:0]  sample_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mask_q, mask_d, value_q, value_d, wdata_q, wdata_d;
  logic [CNT_W-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic              edge_q, edge_d, prev_q, prev_d;
  logic              trig_q, trig_d, ovf_q, ovf_d, wr_q, wr_d;
  logic              match, fire, wr_intent;

  assign match   = ((data_i ^ value_q) & mask_q) == '0;
  assign cnt_inc = cnt_q + CntOne;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    value_d   = value_q;
    edge_d    = edge_q;
    len_d     = len_q;
    prev_d    = prev_q;
    trig_d    = trig_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    wr_intent = 1'b0;
    fire      = edge_q ? (match & ~prev_q) : match;

    if (abort_i) begin
      state_d = StIdle;
      trig_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_i) begin
            state_d = StArmed;
            mask_d  = trig_mask_i;
            value_d = trig_value_i;
            edge_d  = trig_edge_i;
            len_d   = (capture_len_i == '0) ? CntOne : capture_len_i;
            trig_d  = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            // Preset so a pattern already present at arm does not fire in edge mode.
            prev_d  = 1'b1;
          end
        end
        StArmed: begin
          if (strob_i) begin
            prev_d = match;
            if (fire) begin
              trig_d    = 1'b1;
              cnt_d     = CntOne;
              wr_intent = 1'b1;
              state_d   = (len_q == CntOne) ? StDone : StCapture;
            end
          end
        end
        StCapture: begin
          if (strob_i) begin
            cnt_d     = cnt_inc;
            wr_intent = 1'b1;
            if (cnt_inc == len_q) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A dropped sample still counts, so the window length stays fixed.
    if (wr_intent) begin
      if (fifo_full_i) begin
        ovf_d = 1'b1;
      end else begin
        wr_d    = 1'b1;
        wdata_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mask_q  <= '0;
      value_q <= '0;
      edge_q  <= 1'b0;
      len_q   <= '0;
      prev_q  <= 1'b0;
      trig_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      edge_q  <= edge_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign fifo_wr_o    = wr_q;
  assign fifo_data_o  = wdata_q;
  assign busy_o       = (state_q == StArmed) || (state_q == StCapture);
  assign triggered_o  = trig_q;
  assign done_o       = (state_q == StDone);
  assign overflow_o   = ovf_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Bench for capture_trigger: directed scenarios then random traffic against a run-level
// reference model; expected FIFO words are queued and popped by an independent monitor.
module tb_capture_trigger;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, strob, arm, abort, trig_edge, fifo_full;
  logic [DW-1:0] data, trig_mask, trig_value;
  logic [CW-1:0] capture_len;
  logic          fifo_wr, busy, triggered, done, overflow;
  logic [DW-1:0] fifo_data;
  logic [CW-1:0] sample_cnt;

  always #5 clk = ~clk;

  capture_trigger #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .strob_i      (strob),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .trig_edge_i  (trig_edge),
    .capture_len_i(capture_len),
    .fifo_full_i  (fifo_full),
    .fifo_wr_o    (fifo_wr),
    .fifo_data_o  (fifo_data),
    .busy_o       (busy),
    .triggered_o  (triggered),
    .done_o       (done),
    .overflow_o   (overflow),
    .sample_cnt_o (sample_cnt)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  bit            mon_en   = 0;

  // Run-level model: a run is "live" from arm until its window of samples completes.
  bit            m_live, m_fired, m_done, m_trig, m_ovf, m_prev, m_edge, m_wr;
  logic [DW-1:0] m_mask, m_val, m_last;
  int            m_len, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) check("write_expected", 32'(exp_q.size()), 32'd1);
      else check("write_data", 32'(fifo_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic model_write(input logic [DW-1:0] d);
    if (fifo_full) m_ovf = 1;
    else begin
      exp_q.push_back(d);
      m_last = d;
      m_wr   = 1;
    end
  endtask

  task automatic model_step();
    bit hit, fire;
    m_wr = 0;
    if (rst) begin
      {m_live, m_fired, m_done, m_trig, m_ovf} = '0;
      m_cnt  = 0;
      m_last = '0;
    end else if (abort) begin
      {m_live, m_fired, m_done, m_trig, m_ovf} = '0;
    end else if (arm && !m_live) begin
      m_live = 1; m_fired = 0; m_done = 0; m_trig = 0; m_ovf = 0;
      m_cnt  = 0; m_prev = 1;
      m_mask = trig_mask; m_val = trig_value; m_edge = trig_edge;
      m_len  = (capture_len == 0) ? 1 : int'(capture_len);
    end else if (strob && m_live) begin
      hit = ((data ^ m_val) & m_mask) == 0;
      if (!m_fired) begin
        fire   = m_edge ? (hit && !m_prev) : hit;
        m_prev = hit;
        if (fire) begin
          m_fired = 1; m_trig = 1; m_cnt = 1;
          model_write(data);
        end
      end else begin
        m_cnt++;
        model_write(data);
      end
      if (m_fired && m_cnt == m_len) begin
        m_live = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic cyc(input logic [DW-1:0] d, input logic s, input logic a = 0,
                     input logic ab = 0, input logic r = 0, input logic f = 0);
    data = d; strob = s; arm = a; abort = ab; rst = r; fifo_full = f;
    model_step();
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_live));
    check("done", 32'(done), 32'(m_done));
    check("triggered", 32'(triggered), 32'(m_trig));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    check("fifo_wr", 32'(fifo_wr), 32'(m_wr));
    check("fifo_data", 32'(fifo_data), 32'(m_last));
  endtask

  task automatic set_trig(input logic [DW-1:0] mk, input logic [DW-1:0] v, input logic e,
                          input int l);
    trig_mask = mk; trig_value = v; trig_edge = e; capture_len = CW'(l);
  endtask

  initial begin
    logic [DW-1:0] s1[7];
    logic [DW-1:0] s2[4];
    logic [5:0]    gap;
    int            r;
    s1  = '{8'h00, 8'h11, 8'hA5, 8'h22, 8'h33, 8'h44, 8'h55};
    s2  = '{8'h01, 8'h00, 8'h03, 8'h04};
    gap = 6'b100101;
    set_trig('0, '0, 0, 0);
    cyc(8'h00, 0, 0, 0, 1);
    mon_en = 1;
    cyc(8'h00, 0, 0, 0, 1);

    // Level trigger on A5, window of 4.
    set_trig(8'hFF, 8'hA5, 0, 4);
    cyc(8'h00, 0, 1);
    foreach (s1[i]) cyc(s1[i], 1);
    cyc(8'h00, 0);

    // Edge trigger: pattern present at arm must not fire.
    set_trig(8'h01, 8'h01, 1, 2);
    cyc(8'h01, 1, 1);
    foreach (s2[i]) cyc(s2[i], 1);
    cyc(8'h00, 0);

    // Strobe gaps, mask 0 matches everything.
    set_trig(8'h00, 8'h00, 0, 3);
    cyc(8'h00, 0, 1);
    for (int i = 0; i < 6; i++) cyc(DW'(8'h10 + i), gap[i]);
    cyc(8'h00, 0);

    // Overflow on second captured sample, then re-arm clears it.
    set_trig(8'h00, 8'h00, 0, 4);
    cyc(8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(DW'(8'h20 + i), 1, 0, 0, 0, i == 1);
    cyc(8'h00, 0);
    cyc(8'h00, 0, 1);
    cyc(8'h00, 0, 0, 1);

    // Abort after 2 of 10, then re-arm.
    set_trig(8'h00, 8'h00, 0, 10);
    cyc(8'h00, 0, 1);
    cyc(8'h30, 1);
    cyc(8'h31, 1);
    cyc(8'h32, 1, 0, 1);
    cyc(8'h33, 1);
    cyc(8'h34, 1);
    cyc(8'h00, 0, 1);
    cyc(8'h35, 1);
    cyc(8'h00, 0, 0, 1);

    // Reset with a write pending, then arm-while-armed must keep latched settings.
    set_trig(8'h00, 8'h00, 0, 5);
    cyc(8'h00, 0, 1);
    cyc(8'h40, 1);
    cyc(8'h41, 1, 0, 0, 1);
    set_trig(8'hFF, 8'h5A, 0, 2);
    cyc(8'h00, 0, 1);
    set_trig(8'h00, 8'h00, 1, 1);
    cyc(8'h00, 1, 1);
    cyc(8'h00, 1);
    cyc(8'h5A, 1);
    cyc(8'h00, 1);
    cyc(8'h00, 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      logic [DW-1:0] d;
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 2);
        set_trig(r == 0 ? 8'h00 : (r == 1 ? 8'hFF : DW'($urandom)), DW'($urandom_range(0, 7)),
                 1'($urandom), $urandom_range(0, 6));
      end
      d = ($urandom_range(0, 2) == 0) ? trig_value : DW'($urandom_range(0, 15));
      cyc(d, $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0);
    end
    for (int n = 0; n < 4; n++) cyc(8'h00, 0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
